column_sync_scheduler: RTL and testbench
========================================

Name: column_sync_scheduler

Overview:
- Sequences the array of heat-equation column engines: waits for every column to finish memory init, then issues a global one-cycle start pulse per timestep.
- Waits for every column's done flag before the next pulse, and counts completed timesteps against a host-set limit.
- Between timesteps, grants an exclusive readout window to the VGA/HPS reader so grid memory is never read mid-update.
- Sits between the HPS control registers and the column instances.

Parameters:
- NUM_COLS, 16, number of column engines (1..256).
- ITER_BITS, 32, width of the iteration limit and counter.
- TIMEOUT_CYCLES, 65535, watchdog limit in cycles per timestep (used only with WATCHDOG_EN).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- run  in  1  level; 1 = free-run timesteps, 0 = pause at the next timestep boundary.
- step  in  1  single-cycle pulse; executes exactly one timestep while paused.
- max_iters  in  ITER_BITS  stop after this many timesteps; 0 = unlimited.
- init_done  in  NUM_COLS  per-column init-complete flags.
- col_done  in  NUM_COLS  per-column timestep-complete flags, level, cleared by the column after start.
- rd_req  in  1  level; reader requests a readout window.
- rd_done  in  1  single-cycle pulse; reader releases the window.
- start  out  1  one-cycle pulse to all columns.
- rd_grant  out  1  level; readout window is open.
- iter_count  out  ITER_BITS  completed timesteps.
- busy  out  1  high from start pulse until all col_done seen.
- finished  out  1  sticky; iter_count reached max_iters (max_iters != 0).
- error  out  1  sticky watchdog fault (0 when WATCHDOG_EN is undefined).

Behaviour:
- Reset values: start=0, rd_grant=0, iter_count=0, busy=0, finished=0, error=0, state=INIT_WAIT. All outputs are registered.
- all_init = &init_done; all_done = &col_done.
- INIT_WAIT: go to IDLE when all_init=1. rd_grant stays 0.
- IDLE (timestep boundary), evaluated in priority order:
  1. rd_req=1 -> READOUT; rd_grant=1 on the next cycle.
  2. finished=1 -> remain in IDLE.
  3. run=1, or a latched step -> LAUNCH.
  4. Otherwise remain in IDLE.
- step latching: a step pulse arriving in any state other than IDLE is latched. The latch clears when LAUNCH is entered. Multiple pulses collapse to one.
- LAUNCH: start=1 for exactly one cycle, busy=1; next state is GUARD.
- GUARD: two cycles during which col_done is ignored, so stale flags are not counted; then RUN_WAIT.
- RUN_WAIT: when all_done=1 -> busy=0, iter_count+1; then IDLE on the next cycle.
  - finished is set in the same cycle when the incremented count equals max_iters (max_iters != 0).
- Latency: with run=1, no rd_req and columns finishing in C cycles after start, the start-to-start spacing is C+4 cycles minimum.
- READOUT: rd_grant held at 1 until rd_done.
  - On rd_done: rd_grant=0 next cycle, return to IDLE.
  - rd_req deasserting without rd_done does not close the window.
- rd_req during RUN_WAIT is not granted until the timestep completes.
- Pausing: run falling mid-timestep does not abort; the current timestep completes, then the block holds in IDLE.
- iter_count wraps modulo 2^ITER_BITS when max_iters=0.
- Changing max_iters mid-run takes effect at the next comparison.
- If the new max_iters is below the current count, finished stays 0. Lower max_iters only with reset.
- Reset mid-operation returns to INIT_WAIT and clears all counters and flags. Columns are reset by the same signal and must re-report init.
- init_done dropping outside INIT_WAIT is ignored.

Optional Feature:
- Macro: SYNC_WATCHDOG_EN.
- Defined: a cycle counter runs in GUARD/RUN_WAIT and clears at LAUNCH.
  - Reaching TIMEOUT_CYCLES without all_done sets error=1, busy=0 and moves to FAULT.
  - FAULT asserts no further start and grants no readout; only reset exits it.
- Undefined: no counter, error tied to 0, RUN_WAIT waits indefinitely.

Test Plan:
- Init gating: NUM_COLS=4; raise init_done bits one at a time over 20 cycles with run=1 -> no start until all 4 bits are high, then exactly one start pulse within 2 cycles.
- Free-run count: max_iters=3; columns assert done 10 cycles after start -> exactly 3 start pulses, 14 cycles apart; iter_count=3; finished=1; no 4th pulse.
- Stale-flag guard: col_done held at 1 for 1 cycle after start -> iter_count does not increment until done is reasserted.
- Readout arbitration: assert rd_req mid-RUN_WAIT -> rd_grant rises only after completion. No start while rd_grant=1. Pulse rd_done -> rd_grant=0 next cycle, next start follows.
- Pause/step: run=0 in IDLE; pulse step twice during a readout -> one timestep after the window closes; iter_count increments by 1.
- Watchdog (SYNC_WATCHDOG_EN, TIMEOUT_CYCLES=100): one column never asserts done -> error=1 at cycle 100 after start. No further start or rd_grant until reset; reset clears error.

Source files
------------

// File: rtl/column_sync_scheduler.sv
// Timestep sequencer for the heat-equation column array: gates on column init, issues start
// pulses, counts timesteps and opens readout windows only between timesteps.
// Optional watchdog fault detection is compiled in with `define SYNC_WATCHDOG_EN.
module column_sync_scheduler #(
    parameter int NUM_COLS       = 16,
    parameter int ITER_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic [ITER_BITS-1:0] i_max_iters,
    input  logic [NUM_COLS-1:0]  i_init_done,
    input  logic [NUM_COLS-1:0]  i_col_done,
    input  logic                 i_rd_req,
    input  logic                 i_rd_done,
    output logic                 o_start,
    output logic                 o_rd_grant,
    output logic [ITER_BITS-1:0] o_iter_count,
    output logic                 o_busy,
    output logic                 o_finished,
    output logic                 o_error
);

    typedef enum logic [3:0] {
        S_INIT_WAIT = 4'd0,
        S_IDLE      = 4'd1,
        S_LAUNCH    = 4'd2,
        S_GUARD1    = 4'd3,
        S_GUARD2    = 4'd4,
        S_RUN_WAIT  = 4'd5,
        S_COMPLETE  = 4'd6,
        S_READOUT   = 4'd7,
        S_FAULT     = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_start;
    logic                 r_rd_grant;
    logic                 r_busy;
    logic                 r_finished;
    logic                 r_step_pend;
    logic [ITER_BITS-1:0] r_iter_count;
    logic [ITER_BITS-1:0] w_iter_inc;
    logic                 w_all_init;
    logic                 w_all_done;
    logic                 w_step_req;
    logic                 w_hit_limit;
    logic                 w_timeout;

    assign w_all_init  = &i_init_done;
    assign w_all_done  = &i_col_done;
    assign w_step_req  = i_step | r_step_pend;
    assign w_iter_inc  = r_iter_count + ITER_BITS'(1'b1);
    assign w_hit_limit = (i_max_iters != {ITER_BITS{1'b0}}) && (w_iter_inc == i_max_iters);

`ifdef SYNC_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_error;

    // Watchdog counter: equals the number of cycles elapsed since the start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= {WD_W{1'b0}};
        end else if (w_next_state == S_LAUNCH) begin
            r_wd_cnt <= {WD_W{1'b0}};
        end else if ((r_state == S_LAUNCH) || (r_state == S_GUARD1) ||
                     (r_state == S_GUARD2) || (r_state == S_RUN_WAIT)) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1'b1);
        end else begin
            r_wd_cnt <= r_wd_cnt;
        end
    end

    assign w_timeout = (r_wd_cnt >= WD_LAST) &&
                       ((r_state == S_GUARD1) || (r_state == S_GUARD2) || (r_state == S_RUN_WAIT));

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_next_state == S_FAULT) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

    assign o_error = r_error;
`else
    // A negative timeout is not a legal configuration, so this is constantly zero.
    assign w_timeout = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
    assign o_error   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; IDLE is the only point where a readout or new timestep may begin.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT_WAIT: begin
                if (w_all_init) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_INIT_WAIT;
                end
            end
            S_IDLE: begin
                if (i_rd_req) begin
                    w_next_state = S_READOUT;
                end else if (r_finished) begin
                    w_next_state = S_IDLE;
                end else if (i_run || w_step_req) begin
                    w_next_state = S_LAUNCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LAUNCH: w_next_state = S_GUARD1;
            // Columns need two cycles to clear the previous timestep's done flags.
            S_GUARD1: begin
                if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_GUARD2;
                end
            end
            S_GUARD2: begin
                if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_RUN_WAIT;
                end
            end
            S_RUN_WAIT: begin
                if (w_all_done) begin
                    w_next_state = S_COMPLETE;
                end else if (w_timeout) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_next_state = S_RUN_WAIT;
                end
            end
            S_COMPLETE: w_next_state = S_IDLE;
            S_READOUT: begin
                if (i_rd_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_READOUT;
                end
            end
            S_FAULT:    w_next_state = S_FAULT;
            default:    w_next_state = S_INIT_WAIT;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start      <= 1'b0;
            r_rd_grant   <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
            r_iter_count <= {ITER_BITS{1'b0}};
        end else begin
            r_start    <= (w_next_state == S_LAUNCH);
            r_rd_grant <= (w_next_state == S_READOUT);
            if (w_next_state == S_LAUNCH) begin
                r_busy <= 1'b1;
            end else if ((w_next_state == S_COMPLETE) || (w_next_state == S_FAULT)) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
            if (w_next_state == S_COMPLETE) begin
                r_iter_count <= w_iter_inc;
                r_finished   <= r_finished | w_hit_limit;
            end else begin
                r_iter_count <= r_iter_count;
                r_finished   <= r_finished;
            end
        end
    end

    // Step latch: any step not consumed immediately waits for the next launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_pend <= 1'b0;
        end else if (w_next_state == S_LAUNCH) begin
            r_step_pend <= 1'b0;
        end else if (i_step) begin
            r_step_pend <= 1'b1;
        end else begin
            r_step_pend <= r_step_pend;
        end
    end

    assign o_start      = r_start;
    assign o_rd_grant   = r_rd_grant;
    assign o_busy       = r_busy;
    assign o_finished   = r_finished;
    assign o_iter_count = r_iter_count;

endmodule

// File: tb/tb_column_sync_scheduler.sv
// Self-checking bench for column_sync_scheduler: a behavioural column array answers start
// pulses after per-column delays; expectations come from timestep-level arithmetic.
module tb_column_sync_scheduler;
    localparam int NC = 4;
    localparam int IB = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset, run, step, rd_req, rd_done;
    logic [IB-1:0] max_iters;
    logic [NC-1:0] init_done, col_done;
    logic          start, rd_grant, busy, finished, error;
    logic [IB-1:0] iter_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_q[$];
    int col_delay[NC];
    bit col_hang[NC];
    int stale_hold = 0;
    int start_in_grant = 0;

    column_sync_scheduler #(.NUM_COLS(NC), .ITER_BITS(IB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .i_run(run), .i_step(step), .i_max_iters(max_iters),
        .i_init_done(init_done), .i_col_done(col_done), .i_rd_req(rd_req), .i_rd_done(rd_done),
        .o_start(start), .o_rd_grant(rd_grant), .o_iter_count(iter_count), .o_busy(busy),
        .o_finished(finished), .o_error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Column array: each column raises done col_delay clocks after the edge that samples start.
    initial begin : column_model
        int cnt[NC];
        int hold;
        col_done = '0;
        hold = 0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                col_done = '0;
                hold = 0;
                for (int i = 0; i < NC; i++) cnt[i] = 0;
            end else if (start === 1'b1) begin
                start_q.push_back(cyc);
                if (rd_grant === 1'b1) start_in_grant++;
                for (int i = 0; i < NC; i++) cnt[i] = col_delay[i] + 1;
                hold = stale_hold;
                if (hold == 0) col_done = '0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) col_done = '0;
                end
                for (int i = 0; i < NC; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0 && !col_hang[i]) col_done[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : global_bound
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < NC; i++) begin
            col_delay[i] = d;
            col_hang[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        start_q.delete();
        start_in_grant = 0;
    endtask

    task automatic test_reset();
        init_done = '0; run = 1'b0; step = 1'b0; rd_req = 1'b0; rd_done = 1'b0;
        max_iters = '0;
        set_delays(10);
        do_reset();
        tick(1);
        checks++;
        if ({start, rd_grant, busy, finished, error, iter_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got start=%b grant=%b busy=%b fin=%b err=%b iter=%0d want all 0",
                     start, rd_grant, busy, finished, error, iter_count);
        end
    endtask

    task automatic test_init_gating();
        int last;
        run = 1'b1;
        for (int b = 0; b < NC; b++) begin
            tick(5);
            checks++;
            if (start_q.size() != 0) begin
                failures++;
                $display("FAIL init_early_start: got %0d starts with %0d init bits want 0", start_q.size(), b);
            end
            init_done[b] = 1'b1;
        end
        last = cyc;
        tick(3);
        checks++;
        if (start_q.size() != 1) begin
            failures++;
            $display("FAIL init_start_count: got %0d want 1", start_q.size());
        end else begin
            checks++;
            if (start_q[0] - last < 1 || start_q[0] - last > 2) begin
                failures++;
                $display("FAIL init_start_latency: got %0d cycles want 1..2", start_q[0] - last);
            end
        end
        run = 1'b0;
        tick(30);
    endtask

    task automatic test_free_run();
        set_delays(10);
        max_iters = IB'(3);
        run = 1'b1;
        do_reset();
        for (int t = 0; t < 300 && finished !== 1'b1; t++) tick(1);
        tick(40);
        checks++;
        if (start_q.size() != 3) begin
            failures++;
            $display("FAIL freerun_starts: got %0d want 3", start_q.size());
        end
        for (int i = 1; i < start_q.size(); i++) begin
            checks++;
            if (start_q[i] - start_q[i-1] != 14) begin
                failures++;
                $display("FAIL freerun_spacing: got %0d want 14", start_q[i] - start_q[i-1]);
            end
        end
        checks++;
        if (iter_count !== IB'(3) || finished !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL freerun_final: got iter=%0d fin=%b busy=%b want 3 1 0", iter_count, finished, busy);
        end
        run = 1'b0;
    endtask

    task automatic test_stale_guard();
        int s0;
        int sst;
        int inc_cyc;
        set_delays(10);
        max_iters = '0;
        run = 1'b0;
        do_reset();
        tick(3);
        step = 1'b1; tick(1); step = 1'b0;
        for (int t = 0; t < 60 && iter_count !== IB'(1); t++) tick(1);
        tick(3);
        stale_hold = 3;
        s0 = start_q.size();
        step = 1'b1; tick(1); step = 1'b0;
        for (int t = 0; t < 10 && start_q.size() <= s0; t++) tick(1);
        sst = (start_q.size() > s0) ? start_q[$] : cyc;
        while (cyc < sst + 6) tick(1);
        checks++;
        if (iter_count !== IB'(1) || busy !== 1'b1) begin
            failures++;
            $display("FAIL stale_counted: got iter=%0d busy=%b want 1 1", iter_count, busy);
        end
        inc_cyc = -1;
        for (int t = 0; t < 40; t++) begin
            if (iter_count === IB'(2)) begin
                inc_cyc = cyc;
                break;
            end
            tick(1);
        end
        checks++;
        if (inc_cyc != sst + 12) begin
            failures++;
            $display("FAIL stale_completion_cycle: got %0d want %0d", inc_cyc, sst + 12);
        end
        stale_hold = 0;
    endtask

    task automatic test_readout();
        int gc;
        bit early;
        set_delays(10);
        max_iters = '0;
        run = 1'b1;
        do_reset();
        for (int t = 0; t < 20 && start_q.size() < 1; t++) tick(1);
        tick(5);
        rd_req = 1'b1;
        gc = -1;
        early = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick(1);
            if (rd_grant === 1'b1 && busy === 1'b1) early = 1'b1;
            if (rd_grant === 1'b1) begin
                gc = cyc;
                break;
            end
        end
        checks++;
        if (gc < 0 || early || iter_count !== IB'(1)) begin
            failures++;
            $display("FAIL readout_grant: got grant_cyc=%0d early=%b iter=%0d want granted after completion, iter 1",
                     gc, early, iter_count);
        end
        tick(2);
        rd_req = 1'b0;
        tick(6);
        checks++;
        if (rd_grant !== 1'b1 || start_q.size() != 1 || start_in_grant != 0) begin
            failures++;
            $display("FAIL readout_window: got grant=%b starts=%0d starts_in_grant=%0d want 1 1 0",
                     rd_grant, start_q.size(), start_in_grant);
        end
        rd_done = 1'b1; tick(1); rd_done = 1'b0;
        checks++;
        if (rd_grant !== 1'b0) begin
            failures++;
            $display("FAIL readout_release: got grant=%b want 0", rd_grant);
        end
        tick(2);
        checks++;
        if (start_q.size() != 2) begin
            failures++;
            $display("FAIL readout_next_start: got %0d starts want 2", start_q.size());
        end
        run = 1'b0;
        tick(30);
    endtask

    task automatic test_pause_step();
        set_delays(10);
        max_iters = '0;
        run = 1'b1;
        do_reset();
        for (int t = 0; t < 20 && start_q.size() < 1; t++) tick(1);
        tick(4);
        run = 1'b0;
        tick(40);
        checks++;
        if (start_q.size() != 1 || iter_count !== IB'(1) || busy !== 1'b0) begin
            failures++;
            $display("FAIL pause_midstep: got starts=%0d iter=%0d busy=%b want 1 1 0",
                     start_q.size(), iter_count, busy);
        end
        rd_req = 1'b1;
        tick(3);
        checks++;
        if (rd_grant !== 1'b1) begin
            failures++;
            $display("FAIL pause_grant: got %b want 1", rd_grant);
        end
        rd_req = 1'b0;
        step = 1'b1; tick(1); step = 1'b0; tick(2);
        step = 1'b1; tick(1); step = 1'b0; tick(2);
        checks++;
        if (start_q.size() != 1) begin
            failures++;
            $display("FAIL step_during_window: got %0d starts want 1", start_q.size());
        end
        rd_done = 1'b1; tick(1); rd_done = 1'b0;
        tick(40);
        checks++;
        if (start_q.size() != 2 || iter_count !== IB'(2)) begin
            failures++;
            $display("FAIL step_collapse: got starts=%0d iter=%0d want 2 2", start_q.size(), iter_count);
        end
    endtask

    task automatic test_wrap();
        int n;
        n = (1 << IB) + 1;
        set_delays(3);
        max_iters = '0;
        run = 1'b1;
        do_reset();
        for (int t = 0; t < 600 && start_q.size() < n; t++) tick(1);
        run = 1'b0;
        tick(20);
        checks++;
        if (start_q.size() != n || iter_count !== IB'(n % (1 << IB)) || finished !== 1'b0) begin
            failures++;
            $display("FAIL wrap: got starts=%0d iter=%0d fin=%b want %0d %0d 0",
                     start_q.size(), iter_count, finished, n, n % (1 << IB));
        end
    endtask

    task automatic test_random();
        int m;
        int maxd;
        for (int r = 0; r < 4; r++) begin
            m = int'($urandom_range(4, 1));
            maxd = 0;
            for (int i = 0; i < NC; i++) begin
                col_delay[i] = int'($urandom_range(15, 3));
                col_hang[i] = 1'b0;
                if (col_delay[i] > maxd) maxd = col_delay[i];
            end
            max_iters = IB'(m);
            run = 1'b1;
            do_reset();
            for (int t = 0; t < 400 && finished !== 1'b1; t++) tick(1);
            tick(30);
            checks++;
            if (start_q.size() != m || iter_count !== IB'(m) || finished !== 1'b1) begin
                failures++;
                $display("FAIL random_run%0d: got starts=%0d iter=%0d fin=%b want %0d %0d 1",
                         r, start_q.size(), iter_count, finished, m, m);
            end
            for (int i = 1; i < start_q.size(); i++) begin
                checks++;
                if (start_q[i] - start_q[i-1] != maxd + 4) begin
                    failures++;
                    $display("FAIL random_spacing%0d: got %0d want %0d", r, start_q[i] - start_q[i-1], maxd + 4);
                end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_watchdog();
        int s;
        int g;
        set_delays(10);
        col_hang[2] = 1'b1;
        max_iters = '0;
        run = 1'b1;
        do_reset();
        for (int t = 0; t < 20 && start_q.size() < 1; t++) tick(1);
        s = (start_q.size() > 0) ? start_q[0] : cyc;
`ifdef SYNC_WATCHDOG_EN
        for (int t = 0; t < 200 && error !== 1'b1; t++) tick(1);
        checks++;
        if (error !== 1'b1 || cyc != s + TO || busy !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_trip: got err=%b at cycle %0d busy=%b want 1 at %0d busy 0",
                     error, cyc, busy, s + TO);
        end
        rd_req = 1'b1;
        step = 1'b1; tick(1); step = 1'b0;
        g = 0;
        for (int t = 0; t < 30; t++) begin
            tick(1);
            if (rd_grant === 1'b1) g++;
        end
        checks++;
        if (g != 0 || start_q.size() != 1) begin
            failures++;
            $display("FAIL watchdog_fault_hold: got grant_cycles=%0d starts=%0d want 0 1", g, start_q.size());
        end
        rd_req = 1'b0;
        run = 1'b0;
        set_delays(10);
        do_reset();
        tick(1);
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_reset_clear: got err=%b want 0", error);
        end
`else
        g = 0;
        tick(300);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || start_q.size() != 1 || s < 0) begin
            failures++;
            $display("FAIL no_watchdog_wait: got err=%b busy=%b starts=%0d want 0 1 1",
                     error, busy, start_q.size());
        end
        run = 1'b0;
        set_delays(10);
        do_reset();
        tick(1);
        checks++;
        if (busy !== 1'b0 || g != 0) begin
            failures++;
            $display("FAIL no_watchdog_reset: got busy=%b want 0", busy);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_init_gating();
        test_free_run();
        test_stale_guard();
        test_readout();
        test_pause_step();
        test_wrap();
        test_random();
        test_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
